pi_ray_fifo_writer: RTL and testbench

- Sits directly upstream of the UDP control-data TX packetizer.
- Takes the PI controller output stream and the ray (photodiode) sample stream and pairs them.
- Averages each pair stream over a power-of-two decimation window and writes the PI output FIFO and the ray FIFO in the same cycle.
- Guarantee to the downstream stage: "PI FIFO not empty" always implies "ray FIFO holds the matching word".

---
 rtl/pi_ray_fifo_writer_pkg.sv | 26 ++
 rtl/pi_ray_fifo_writer_averager.sv | 62 ++++++
 rtl/pi_ray_fifo_writer.sv | 136 +++++++++++++
 tb/tb_pi_ray_fifo_writer.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pi_ray_fifo_writer_pkg.sv
// Shared constants and types for the PI/ray FIFO writer
// and the TX packetizer that drains its two FIFOs.
package pi_ray_fifo_writer_pkg;

  localparam int FIFO_LENGTH   = 16;
  localparam int MAX_DEC_LOG2  = 8;
  localparam int DROP_CNT_SIZE = 16;
  localparam int nOfFifos      = 2;
  localparam int KW            = 4;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  function automatic logic [KW-1:0] clamp_k(
    input logic [KW-1:0] d,
    input int            maxk
  );
    logic [31:0] m;
    m = 32'(maxk);
    if (int'(d) > maxk) return m[KW-1:0];
    return d;
  endfunction

endpackage

// File: rtl/pi_ray_fifo_writer_averager.sv
// One-stream power-of-two window accumulator: sum, count,
// and floor-shift of the window total.
module pow2_window_averager #(
  parameter int W    = 16,
  parameter int MAXK = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr_i,
  input  logic         valid_i,
  input  logic         win_done_i,
  input  logic [3:0]   k_i,
  input  logic [W-1:0] sample_i,
  output logic         done_o,
  output logic [W-1:0] avg_o
);

  localparam int AW = W + MAXK;
  localparam int SW = MAXK + 1;

  logic signed [AW-1:0] acc_q, acc_d;
  logic signed [AW-1:0] sum;
  logic signed [AW-1:0] shr;
  logic [MAXK-1:0]      cnt_q, cnt_d;
  logic [SW-1:0]        span;
  logic [SW-1:0]        last_w;

  assign sum    = acc_q + {{MAXK{sample_i[W-1]}}, sample_i};
  assign shr    = sum >>> k_i;
  assign avg_o  = shr[W-1:0];
  assign span   = SW'(1) << k_i;
  assign last_w = span - SW'(1);
  assign done_o = valid_i && (cnt_q == last_w[MAXK-1:0]);

  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (clr_i) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (valid_i) begin
      if (win_done_i) begin
        acc_d = '0;
        cnt_d = '0;
      end else begin
        acc_d = sum;
        cnt_d = cnt_q + MAXK'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pi_ray_fifo_writer.sv
// Pairs PI output with held ray samples, window-averages both
// and writes the two FIFOs together or not at all.
module pi_ray_fifo_writer #(
  parameter int FIFO_LENGTH   = pi_ray_fifo_writer_pkg::FIFO_LENGTH,
  parameter int MAX_DEC_LOG2  = pi_ray_fifo_writer_pkg::MAX_DEC_LOG2,
  parameter int DROP_CNT_SIZE = pi_ray_fifo_writer_pkg::DROP_CNT_SIZE
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [3:0]               decim_log2,
  input  logic [FIFO_LENGTH-1:0]   pi_data_in,
  input  logic                     pi_valid,
  input  logic [FIFO_LENGTH-1:0]   ray_data_in,
  input  logic                     ray_valid,
  output logic                     pi_wrreq_output_fifo,
  output logic [FIFO_LENGTH-1:0]   pi_wrdata_output_fifo,
  input  logic                     pi_wrfull_output_fifo,
  output logic                     ray_wrreq_fifo,
  output logic [FIFO_LENGTH-1:0]   ray_wrdata_fifo,
  input  logic                     ray_wrfull_fifo,
  output logic [DROP_CNT_SIZE-1:0] drop_count,
  output logic                     busy
);

  import pi_ray_fifo_writer_pkg::*;

  state_t                   state_q, state_d;
  logic [3:0]               k_q, k_d;
  logic [FIFO_LENGTH-1:0]   ray_hold_q;
  logic [FIFO_LENGTH-1:0]   ray_eff;
  logic                     run_v;
  logic                     clr;
  logic                     pi_done, ray_done;
  logic                     emit, full;
  logic [FIFO_LENGTH-1:0]   pi_avg, ray_avg;
  logic                     wr_q;
  logic [FIFO_LENGTH-1:0]   pi_wd_q, ray_wd_q;
  logic [DROP_CNT_SIZE-1:0] drop_q;

  // A ray strobe coinciding with the PI strobe wins over the hold
  assign ray_eff = ray_valid ? ray_data_in : ray_hold_q;
  assign run_v   = (state_q == RUN) && enable && pi_valid;
  assign clr     = (state_q == IDLE);
  assign emit    = pi_done && ray_done;
  assign full    = pi_wrfull_output_fifo || ray_wrfull_fifo;

  pow2_window_averager #(
    .W    (FIFO_LENGTH),
    .MAXK (MAX_DEC_LOG2)
  ) u_pi_avg (
    .clk        (clk),
    .reset      (reset),
    .clr_i      (clr),
    .valid_i    (run_v),
    .win_done_i (pi_done),
    .k_i        (k_q),
    .sample_i   (pi_data_in),
    .done_o     (pi_done),
    .avg_o      (pi_avg)
  );

  pow2_window_averager #(
    .W    (FIFO_LENGTH),
    .MAXK (MAX_DEC_LOG2)
  ) u_ray_avg (
    .clk        (clk),
    .reset      (reset),
    .clr_i      (clr),
    .valid_i    (run_v),
    .win_done_i (pi_done),
    .k_i        (k_q),
    .sample_i   (ray_eff),
    .done_o     (ray_done),
    .avg_o      (ray_avg)
  );

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    unique case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = RUN;
          k_d     = clamp_k(decim_log2, MAX_DEC_LOG2);
        end
      end
      RUN: begin
        if (!enable) begin
          state_d = IDLE;
        end else if (emit) begin
          k_d = clamp_k(decim_log2, MAX_DEC_LOG2);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      k_q        <= '0;
      ray_hold_q <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      if (ray_valid) ray_hold_q <= ray_data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q     <= 1'b0;
      pi_wd_q  <= '0;
      ray_wd_q <= '0;
      drop_q   <= '0;
    end else begin
      wr_q <= emit && !full;
      if (emit && !full) begin
        pi_wd_q  <= pi_avg;
        ray_wd_q <= ray_avg;
      end
      if (emit && full && (drop_q != '1)) begin
        drop_q <= drop_q + DROP_CNT_SIZE'(1);
      end
    end
  end

  assign pi_wrreq_output_fifo  = wr_q;
  assign ray_wrreq_fifo        = wr_q;
  assign pi_wrdata_output_fifo = pi_wd_q;
  assign ray_wrdata_fifo       = ray_wd_q;
  assign drop_count            = drop_q;
  assign busy                  = (state_q == RUN);

endmodule

// File: tb/tb_pi_ray_fifo_writer.sv
// Scoreboard bench for pi_ray_fifo_writer: a behavioural window
// model queues expected FIFO words, a monitor pops them.
module tb_pi_ray_fifo_writer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [3:0]  decim_log2 = 4'd0;
  logic [15:0] pi_data_in = '0;
  logic        pi_valid = 1'b0;
  logic [15:0] ray_data_in = '0;
  logic        ray_valid = 1'b0;
  logic        pi_wrreq_output_fifo;
  logic [15:0] pi_wrdata_output_fifo;
  logic        pi_wrfull_output_fifo = 1'b0;
  logic        ray_wrreq_fifo;
  logic [15:0] ray_wrdata_fifo;
  logic        ray_wrfull_fifo = 1'b0;
  logic [15:0] drop_count;
  logic        busy;

  pi_ray_fifo_writer dut (
    .clk                   (clk),
    .reset                 (reset),
    .enable                (enable),
    .decim_log2            (decim_log2),
    .pi_data_in            (pi_data_in),
    .pi_valid              (pi_valid),
    .ray_data_in           (ray_data_in),
    .ray_valid             (ray_valid),
    .pi_wrreq_output_fifo  (pi_wrreq_output_fifo),
    .pi_wrdata_output_fifo (pi_wrdata_output_fifo),
    .pi_wrfull_output_fifo (pi_wrfull_output_fifo),
    .ray_wrreq_fifo        (ray_wrreq_fifo),
    .ray_wrdata_fifo       (ray_wrdata_fifo),
    .ray_wrfull_fifo       (ray_wrfull_fifo),
    .drop_count            (drop_count),
    .busy                  (busy)
  );

  always #4 clk = ~clk;

  typedef struct {
    logic [15:0] pi;
    logic [15:0] ray;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;

  int                 m_sp, m_sr, m_cnt, m_k;
  logic signed [15:0] m_hold;
  int                 exp_drop;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (pi_wrreq_output_fifo || ray_wrreq_fifo) begin
      chk("wrreq_pair", 32'(ray_wrreq_fifo), 32'(pi_wrreq_output_fifo));
      if (sb.size() == 0) begin
        chk("unexpected_wr", 32'(1), 32'(0));
      end else begin
        e = sb.pop_front();
        chk("pi_word", 32'(pi_wrdata_output_fifo), 32'(e.pi));
        chk("ray_word", 32'(ray_wrdata_fifo), 32'(e.ray));
        chk("wr_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  function automatic int klog(input logic [3:0] d);
    return (d > 4'd8) ? 8 : int'(d);
  endfunction

  task automatic model_clear();
    m_sp  = 0;
    m_sr  = 0;
    m_cnt = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic signed [15:0] p, input logic rv,
                      input logic signed [15:0] r);
    logic signed [15:0] rr;
    exp_t e;
    int sp, sr;
    pi_data_in  = p;
    pi_valid    = 1'b1;
    ray_data_in = r;
    ray_valid   = rv;
    if (rv) m_hold = r;
    rr = m_hold;
    m_sp += int'(p);
    m_sr += int'(rr);
    m_cnt++;
    if (m_cnt == (1 << m_k)) begin
      sp = m_sp >>> m_k;
      sr = m_sr >>> m_k;
      if (pi_wrfull_output_fifo || ray_wrfull_fifo) begin
        exp_drop++;
      end else begin
        e.pi  = sp[15:0];
        e.ray = sr[15:0];
        e.cyc = cyc + 1;
        sb.push_back(e);
      end
      model_clear();
      m_k = klog(decim_log2);
    end
    tick();
    pi_valid  = 1'b0;
    ray_valid = 1'b0;
  endtask

  task automatic ray_only(input logic signed [15:0] r);
    ray_data_in = r;
    ray_valid   = 1'b1;
    m_hold      = r;
    tick();
    ray_valid = 1'b0;
  endtask

  task automatic start_run(input logic [3:0] d);
    decim_log2 = d;
    enable     = 1'b1;
    tick();
    m_k = klog(d);
    model_clear();
    chk("busy_run", 32'(busy), 32'(1));
  endtask

  task automatic stop_run();
    enable = 1'b0;
    tick();
    model_clear();
    chk("busy_idle", 32'(busy), 32'(0));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    m_hold   = '0;
    exp_drop = 0;
    m_k      = 0;
    model_clear();
    tick();
    tick();
    reset = 1'b0;
    chk("rst_wrreq", 32'(pi_wrreq_output_fifo), 32'(0));
    chk("rst_pi_data", 32'(pi_wrdata_output_fifo), 32'(0));
    chk("rst_ray_data", 32'(ray_wrdata_fifo), 32'(0));
    chk("rst_drop", 32'(drop_count), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));

    // k=0 back-to-back pass-through
    start_run(4'd0);
    send(16'sh0001, 1'b1, 16'sh0100);
    send(16'sh0002, 1'b0, 16'sh0000);
    send(16'sh0003, 1'b0, 16'sh0000);
    send(16'sh0004, 1'b0, 16'sh0000);
    idle(3);
    stop_run();

    // k=2 averaging with negative held ray
    start_run(4'd2);
    ray_only(-16'sd4);
    send(16'sd10, 1'b0, 16'sd0);
    send(16'sd11, 1'b0, 16'sd0);
    send(16'sd12, 1'b0, 16'sd0);
    idle(2);
    send(16'sd13, 1'b0, 16'sd0);
    idle(3);
    stop_run();

    // k=1 floor of a negative sum
    start_run(4'd1);
    send(-16'sd3, 1'b1, 16'sd7);
    send(-16'sd2, 1'b1, -16'sd8);
    idle(3);
    stop_run();

    // k=2 with ray FIFO full on the completing sample
    start_run(4'd2);
    for (int i = 0; i < 3; i++) send(16'(20 + i), 1'b1, 16'(i));
    ray_wrfull_fifo = 1'b1;
    send(16'sd23, 1'b0, 16'sd0);
    ray_wrfull_fifo = 1'b0;
    idle(2);
    chk("drop_one", 32'(drop_count), 32'(exp_drop));
    pi_wrfull_output_fifo = 1'b1;
    idle(1);
    pi_wrfull_output_fifo = 1'b0;
    for (int i = 0; i < 4; i++) send(16'(-100 + i), 1'b1, 16'(300 * i));
    idle(3);
    stop_run();

    // k=3 partial window discarded by enable drop
    start_run(4'd3);
    for (int i = 0; i < 5; i++) send(16'sh7000, 1'b1, 16'sh7000);
    stop_run();
    start_run(4'd3);
    for (int i = 0; i < 8; i++) send(16'(i * 5), 1'b1, 16'(-i));
    idle(3);

    // reset mid-window
    for (int i = 0; i < 3; i++) send(16'sd99, 1'b1, 16'sd99);
    enable = 1'b0;
    reset  = 1'b1;
    tick();
    reset  = 1'b0;
    m_hold = '0;
    exp_drop = 0;
    model_clear();
    idle(2);
    chk("rst_mid_drop", 32'(drop_count), 32'(0));
    chk("rst_mid_busy", 32'(busy), 32'(0));

    // decim change mid-window takes effect on next window
    start_run(4'd2);
    send(16'sd1, 1'b1, 16'sd2);
    send(16'sd2, 1'b0, 16'sd0);
    decim_log2 = 4'd0;
    send(16'sd3, 1'b0, 16'sd0);
    send(16'sd6, 1'b1, 16'sd10);
    send(-16'sd7, 1'b0, 16'sd0);
    send(16'sh7FFF, 1'b1, 16'sh8000);
    send(16'sd5, 1'b0, 16'sd0);
    idle(3);
    stop_run();

    // decim 15 clamps to 256-sample windows
    start_run(4'd15);
    for (int i = 0; i < 256; i++) begin
      send(16'(i), 1'b1, 16'(-3 * i));
      if (i == 254) chk("no_early_wr", 32'(sb.size()), 32'(0));
    end
    idle(3);
    stop_run();

    chk("sb_empty", 32'(sb.size()), 32'(0));
    chk("drop_final", 32'(drop_count), 32'(exp_drop));
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
